// File: rtl/mux4_scan_seq_pkg.sv
// Shared definitions for the 4-channel mux scan sequencer.
package mux4_scan_seq_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mux4_scan_seq_next_ch_find.sv
// Finds the next enabled channel: lowest set mask bit above cur, or the
// lowest set bit overall when first is high.
module next_ch_find
    import mux4_scan_seq_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              first,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        // Walk downwards so the lowest qualifying channel is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (SEL_W'(i) > cur))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_scan_seq.sv
// Scan sequencer feeding a downstream 4:1 mux: captures data/mask/dwell on
// start and steps sel through enabled channels, each held dwell+1 cycles.
module mux4_scan_seq
    import mux4_scan_seq_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in0,
    input  logic               in1,
    input  logic               in2,
    input  logic               in3,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic               d0,
    output logic               d1,
    output logic               d2,
    output logic               d3,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [NUM_CH-1:0]  dat_q, dat_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NUM_CH-1:0]  f_mask;
    logic               f_first;
    logic [SEL_W-1:0]   f_nxt;
    logic               f_found;

    // In IDLE the search runs on the live mask so the first channel is ready at the start edge.
    always_comb begin
        f_first = (state_q == ST_IDLE);
        f_mask  = f_first ? mask : mask_q;
    end

    next_ch_find u_find (
        .mask  (f_mask),
        .cur   (sel_q),
        .first (f_first),
        .nxt   (f_nxt),
        .found (f_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dat_d   = {in3, in2, in1, in0};
                    mask_d  = mask;
                    dwell_d = dwell;
                    cnt_d   = '0;
                    if (f_found) begin
                        state_d = ST_SCAN;
                        sel_d   = f_nxt;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SCAN: begin
                if (cnt_q < dwell_q) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (f_found) sel_d = f_nxt;
                    else         state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are registered versions of the upcoming state.
    always_comb begin
        valid_d = (state_d == ST_SCAN);
        busy_d  = (state_d == ST_SCAN) || (state_d == ST_DONE);
        done_d  = (state_d == ST_DONE);
    end

    assign sel   = sel_q;
    assign d0    = dat_q[0];
    assign d1    = dat_q[1];
    assign d2    = dat_q[2];
    assign d3    = dat_q[3];
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mux4_scan_seq.sv
// Directed bench for mux4_scan_seq with hand-computed expectations.
module tb_mux4_scan_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in0, in1, in2, in3;
    logic [3:0] mask;
    logic [3:0] dwell;
    logic [1:0] sel;
    logic       d0, d1, d2, d3;
    logic       valid, busy, done;

    int n_chk;
    int n_pass;
    int vcnt;

    mux4_scan_seq #(.DWELL_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in0   (in0),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .mask  (mask),
        .dwell (dwell),
        .sel   (sel),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Packs {sel, valid, busy, done}.
    task automatic chk_st(input string tag, input logic [1:0] es, input logic ev,
                          input logic eb, input logic ed);
        chk(tag, {3'b0, sel, valid, busy, done}, {3'b0, es, ev, eb, ed});
    endtask

    task automatic chk_d(input string tag, input logic [3:0] ed);
        chk(tag, {4'b0, d3, d2, d1, d0}, {4'b0, ed});
    endtask

    function automatic logic mux_out();
        logic [3:0] dv;
        dv = {d3, d2, d1, d0};
        return dv[sel];
    endfunction

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        start  = 1'b1;
        {in3, in2, in1, in0} = 4'b1111;
        mask   = 4'b1111;
        dwell  = 4'd0;

        // Reset held 2 cycles with start high
        tick();
        chk_st("rst_c1", 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_st("rst_c2", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_d("rst_d", 4'b0000);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk_st("rst_idle", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_d("rst_idle_d", 4'b0000);

        // Full scan, dwell 0, in={1,0,1,1}
        in0 = 1'b1; in1 = 1'b0; in2 = 1'b1; in3 = 1'b1;
        mask = 4'b1111; dwell = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_st("full_s0", 2'd0, 1'b1, 1'b1, 1'b0);
        chk_d("full_d", 4'b1101);
        chk("full_mux0", {7'b0, mux_out()}, 8'd1);
        tick();
        chk_st("full_s1", 2'd1, 1'b1, 1'b1, 1'b0);
        chk("full_mux1", {7'b0, mux_out()}, 8'd0);
        tick();
        chk_st("full_s2", 2'd2, 1'b1, 1'b1, 1'b0);
        chk("full_mux2", {7'b0, mux_out()}, 8'd1);
        tick();
        chk_st("full_s3", 2'd3, 1'b1, 1'b1, 1'b0);
        chk("full_mux3", {7'b0, mux_out()}, 8'd1);
        tick();
        chk_st("full_done", 2'd3, 1'b0, 1'b1, 1'b1);
        tick();
        chk_st("full_idle", 2'd3, 1'b0, 1'b0, 1'b0);
        chk_d("full_idle_d", 4'b1101);

        // Skip and dwell: mask 1010, dwell 2
        mask = 4'b1010; dwell = 4'd2; start = 1'b1;
        {in3, in2, in1, in0} = 4'b0110;
        tick();
        start = 1'b0;
        vcnt  = 0;
        for (int i = 0; i < 6; i++) begin
            chk_st("skip_scan", (i < 3) ? 2'd1 : 2'd3, 1'b1, 1'b1, 1'b0);
            if (valid) vcnt++;
            tick();
        end
        chk_st("skip_done", 2'd3, 1'b0, 1'b1, 1'b1);
        chk("skip_vcnt", 8'(vcnt), 8'd6);
        tick();
        chk_st("skip_idle", 2'd3, 1'b0, 1'b0, 1'b0);

        // Empty mask goes straight to DONE
        mask = 4'b0000; dwell = 4'd5; start = 1'b1;
        {in3, in2, in1, in0} = 4'b1001;
        tick();
        start = 1'b0;
        chk_st("empty_done", 2'd3, 1'b0, 1'b1, 1'b1);
        chk_d("empty_d", 4'b1001);
        tick();
        chk_st("empty_idle", 2'd3, 1'b0, 1'b0, 1'b0);

        // Interference during a scan: mask 1111, dwell 1
        {in3, in2, in1, in0} = 4'b0110;
        mask = 4'b1111; dwell = 4'd1; start = 1'b1;
        tick();
        chk_st("intf_s0", 2'd0, 1'b1, 1'b1, 1'b0);
        vcnt = 1;
        for (int i = 1; i < 8; i++) begin
            {in3, in2, in1, in0} = ~{in3, in2, in1, in0};
            mask  = 4'b0001;
            dwell = 4'd0;
            start = (i < 7);
            tick();
            chk_st("intf_scan", 2'(i / 2), 1'b1, 1'b1, 1'b0);
            chk_d("intf_d", 4'b0110);
            if (valid) vcnt++;
        end
        tick();
        chk_st("intf_done", 2'd3, 1'b0, 1'b1, 1'b1);
        chk("intf_vcnt", 8'(vcnt), 8'd8);
        tick();
        chk_st("intf_idle", 2'd3, 1'b0, 1'b0, 1'b0);

        // Reset at the 3rd SCAN cycle, then a clean scan
        {in3, in2, in1, in0} = 4'b0011;
        mask = 4'b1111; dwell = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_st("mrst_pre", 2'd0, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_st("mrst_out", 2'd0, 1'b0, 1'b0, 1'b0);
        chk_d("mrst_d", 4'b0000);
        tick();
        chk_st("mrst_idle", 2'd0, 1'b0, 1'b0, 1'b0);
        {in3, in2, in1, in0} = 4'b1111;
        mask = 4'b0100; dwell = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_st("mrst_s2", 2'd2, 1'b1, 1'b1, 1'b0);
        chk_d("mrst_new_d", 4'b1111);
        tick();
        chk_st("mrst_done", 2'd2, 1'b0, 1'b1, 1'b1);
        tick();
        chk_st("mrst_end", 2'd2, 1'b0, 1'b0, 1'b0);

        // Maximum dwell on channel 3 only: 16 cycles, counter must not wrap
        mask = 4'b1000; dwell = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        vcnt  = 0;
        for (int i = 0; i < 16; i++) begin
            if (valid && sel == 2'd3) vcnt++;
            tick();
        end
        chk("max_vcnt", 8'(vcnt), 8'd16);
        chk_st("max_done", 2'd3, 1'b0, 1'b1, 1'b1);

        // Start held through DONE retriggers after one IDLE cycle
        mask = 4'b0001; dwell = 4'd0; start = 1'b1;
        tick();
        chk_st("hold_idle", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        chk_st("hold_s0", 2'd0, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk_st("hold_done", 2'd0, 1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
